// File: rtl/dp_ram_wr_arbiter.sv
// ---------------------------------------------------------------------------
// dp_ram_wr_arbiter
//
// Shares the single write port of the 8x16 dual-port RAM among NUM_REQ
// requesters. Arbitration is round-robin. The write controls are registered
// and drive the RAM's wr_en/wr_addr/data_in directly. Everything runs in the
// wr_clk domain.
//
// Optional feature macro: RAM_SCRUB_EN
//   When defined, a post-reset scrub zero-fills every RAM word before any
//   requester is served. When undefined, the block starts directly in RUN.
//
// Ports:
//   wr_clk       in   write clock, all state changes on posedge
//   rst          in   asynchronous, active-high reset
//   req_valid    in   [NUM_REQ]           per-requester write pending
//   req_ready    out  [NUM_REQ]           one-hot grant (or zero), combinational
//   req_addr     in   [NUM_REQ*ADDR_SIZE] flattened addresses, slot i at i*ADDR_SIZE
//   req_data     in   [NUM_REQ*RAM_WIDTH] flattened data, slot i at i*RAM_WIDTH
//   ram_wr_en    out  registered RAM write enable
//   ram_wr_addr  out  registered RAM write address
//   ram_data_in  out  registered RAM write data
//   grant_id     out  registered index of the requester behind ram_wr_en
//   busy         out  high while scrubbing
//
// Handshake: requester i transfers on a posedge where req_valid[i] and
// req_ready[i] are both high. A requester holds valid/addr/data stable until
// it sees ready, and may drop valid only after the transfer. req_ready never
// depends on the requester's own addr/data, only on valid and the pointer.
// ---------------------------------------------------------------------------
module dp_ram_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 8,
    parameter int ADDR_SIZE = 3
) (
    input  logic                          wr_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]  req_addr,
    input  logic [NUM_REQ*RAM_WIDTH-1:0]  req_data,
    output logic                          ram_wr_en,
    output logic [ADDR_SIZE-1:0]          ram_wr_addr,
    output logic [RAM_WIDTH-1:0]          ram_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    // Elaboration-time parameter sanity checks.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("dp_ram_wr_arbiter: NUM_REQ must be in 2..8");
    end
    if (RAM_DEPTH < 1 || RAM_DEPTH > (1 << ADDR_SIZE)) begin : g_bad_depth
        $error("dp_ram_wr_arbiter: RAM_DEPTH does not fit ADDR_SIZE");
    end

    logic [ID_W-1:0]      last_grant;
    logic [ID_W-1:0]      win_idx;
    logic [ID_W-1:0]      cand;
    logic                 win_found;
    logic                 transfer;
    logic                 scrub_active;
    logic                 scrub_wr;
    logic [ADDR_SIZE-1:0] scrub_addr;

`ifdef RAM_SCRUB_EN
    localparam int SCW = ADDR_SIZE + 1;
    // One extra count past the last address gives a no-write cycle, so busy
    // falls on the same edge that clears the last scrub write.
    localparam logic [SCW-1:0] SCRUB_END = SCW'(RAM_DEPTH);

    typedef enum logic {
        ST_SCRUB = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [SCW-1:0] scrub_cnt;

    // State register
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) state <= ST_SCRUB;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (state == ST_SCRUB && scrub_cnt == SCRUB_END) state_nxt = ST_RUN;
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst)           scrub_cnt <= '0;
        else if (scrub_wr) scrub_cnt <= scrub_cnt + SCW'(1);
    end

    always_comb begin
        scrub_active = (state == ST_SCRUB);
        scrub_wr     = scrub_active && (scrub_cnt != SCRUB_END);
        scrub_addr   = scrub_cnt[ADDR_SIZE-1:0];
    end
`else
    always_comb begin
        scrub_active = 1'b0;
        scrub_wr     = 1'b0;
        scrub_addr   = '0;
    end
`endif

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_grant;
        cand      = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(last_grant) + off) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Output logic: grant is suppressed while scrubbing or in reset.
    always_comb begin
        req_ready = '0;
        busy      = scrub_active;
        if (!rst && !scrub_active && win_found) req_ready[win_idx] = 1'b1;
    end

    assign transfer = |(req_valid & req_ready);

    // Registered write port and round-robin pointer.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_data_in <= '0;
            grant_id    <= '0;
            last_grant  <= LAST_ID;
        end else begin
            ram_wr_en <= 1'b0;
            if (scrub_wr) begin
                ram_wr_en   <= 1'b1;
                ram_wr_addr <= scrub_addr;
                ram_data_in <= '0;
            end else if (transfer) begin
                ram_wr_en   <= 1'b1;
                ram_wr_addr <= req_addr[win_idx*ADDR_SIZE +: ADDR_SIZE];
                ram_data_in <= req_data[win_idx*RAM_WIDTH +: RAM_WIDTH];
                grant_id    <= win_idx;
                last_grant  <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dp_ram_wr_arbiter
//
// Self-checking bench for dp_ram_wr_arbiter. Works with and without
// RAM_SCRUB_EN. A behavioural model holds the pending requests, the
// round-robin pointer as a plain integer and the scrub progress; every
// expected RAM write is queued in exp_q and compared the cycle after it is
// granted. A small RAM model captures the DUT's write port.
// ---------------------------------------------------------------------------
module tb_dp_ram_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int RAM_WIDTH = 16;
    localparam int RAM_DEPTH = 8;
    localparam int ADDR_SIZE = 3;
    localparam int ID_W      = 2;
    localparam int ITEM_W    = 1 + ID_W + ADDR_SIZE + RAM_WIDTH;
`ifdef RAM_SCRUB_EN
    localparam bit SCRUB_ON = 1'b1;
`else
    localparam bit SCRUB_ON = 1'b0;
`endif

    logic                         wr_clk;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ*RAM_WIDTH-1:0] req_data;
    logic                         ram_wr_en;
    logic [ADDR_SIZE-1:0]         ram_wr_addr;
    logic [RAM_WIDTH-1:0]         ram_data_in;
    logic [ID_W-1:0]              grant_id;
    logic                         busy;

    dp_ram_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .RAM_WIDTH(RAM_WIDTH),
        .RAM_DEPTH(RAM_DEPTH),
        .ADDR_SIZE(ADDR_SIZE)
    ) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_data_in(ram_data_in),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    initial begin
        wr_clk = 1'b0;
        forever #5 wr_clk = ~wr_clk;
    end

    // ---------------- RAM model ----------------
    logic [RAM_WIDTH-1:0] mem     [RAM_DEPTH];
    bit                   mem_wrt [RAM_DEPTH];

    always @(posedge wr_clk) begin
        if (ram_wr_en) begin
            mem[ram_wr_addr]     <= ram_data_in;
            mem_wrt[ram_wr_addr] <= 1'b1;
        end
    end

    // Words never written read back as a recognisable non-zero pattern.
    function automatic logic [RAM_WIDTH-1:0] mem_rd(input int a);
        return mem_wrt[a] ? mem[a] : 16'hDEAD;
    endfunction

    // ---------------- requester state and reference model ----------------
    bit                   pend   [NUM_REQ];
    logic [ADDR_SIZE-1:0] p_addr [NUM_REQ];
    logic [RAM_WIDTH-1:0] p_data [NUM_REQ];

    logic [ITEM_W-1:0]    exp_q[$];
    int                   mdl_last;
    bit                   mdl_scrub;
    int                   mdl_scnt;
    logic [ADDR_SIZE-1:0] hold_addr;
    logic [RAM_WIDTH-1:0] hold_data;
    logic [ID_W-1:0]      hold_gid;

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        exp_q.delete();
        mdl_last  = NUM_REQ - 1;
        mdl_scrub = SCRUB_ON;
        mdl_scnt  = 0;
        hold_addr = '0;
        hold_data = '0;
        hold_gid  = '0;
    endtask

    task automatic new_req(input int i, input logic [ADDR_SIZE-1:0] a, input logic [RAM_WIDTH-1:0] d);
        pend[i]   = 1'b1;
        p_addr[i] = a;
        p_data[i] = d;
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = pend[i];
            req_addr[i*ADDR_SIZE +: ADDR_SIZE] = pend[i] ? p_addr[i] : ADDR_SIZE'($urandom);
            req_data[i*RAM_WIDTH +: RAM_WIDTH] = pend[i] ? p_data[i] : RAM_WIDTH'($urandom);
        end
    endtask

    // One clock cycle: drive, check at the negedge, advance the model,
    // return 1 time unit after the next posedge.
    task automatic tick();
        logic [ITEM_W-1:0]  it;
        logic [NUM_REQ-1:0] exp_ready;
        int                 w;
        int                 c;
        drive();
        @(negedge wr_clk);
        if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            hold_addr = it[RAM_WIDTH +: ADDR_SIZE];
            hold_data = it[RAM_WIDTH-1:0];
            chk("wr_en_high", 32'(ram_wr_en), 32'd1);
            chk("wr_addr", 32'(ram_wr_addr), 32'(hold_addr));
            chk("wr_data", 32'(ram_data_in), 32'(hold_data));
            if (it[ITEM_W-1]) begin
                hold_gid = it[RAM_WIDTH+ADDR_SIZE +: ID_W];
                chk("grant_id", 32'(grant_id), 32'(hold_gid));
            end
        end else begin
            chk("wr_en_low", 32'(ram_wr_en), 32'd0);
            chk("wr_addr_hold", 32'(ram_wr_addr), 32'(hold_addr));
            chk("wr_data_hold", 32'(ram_data_in), 32'(hold_data));
            chk("grant_id_hold", 32'(grant_id), 32'(hold_gid));
        end
        chk("busy", 32'(busy), 32'(mdl_scrub));

        exp_ready = '0;
        if (mdl_scrub) begin
            if (mdl_scnt < RAM_DEPTH) begin
                exp_q.push_back({1'b0, ID_W'(0), ADDR_SIZE'(mdl_scnt), RAM_WIDTH'(0)});
                mdl_scnt++;
            end else begin
                mdl_scrub = 1'b0;
            end
        end else begin
            w = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
                c = (mdl_last + k) % NUM_REQ;
                if (w < 0 && pend[c]) w = c;
            end
            if (w >= 0) begin
                exp_ready = NUM_REQ'(1) << w;
                exp_q.push_back({1'b1, ID_W'(w), p_addr[w], p_data[w]});
                mdl_last = w;
                pend[w]  = 1'b0;
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge wr_clk);
        #1;
    endtask

    task automatic apply_reset();
        drive();
        rst = 1'b1;
        #1;
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(ram_data_in), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'(SCRUB_ON));
        @(posedge wr_clk);
        #1;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        mdl_reset();
    endtask

    task automatic drain_scrub();
        for (int k = 0; k < RAM_DEPTH + 4 && mdl_scrub; k++) tick();
    endtask

    task automatic drain_pending();
        bit any;
        for (int k = 0; k < 4 * NUM_REQ; k++) begin
            any = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) any |= pend[i];
            if (!any) break;
            tick();
        end
        tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [RAM_WIDTH-1:0] d1;
        logic [RAM_WIDTH-1:0] old6;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        mdl_reset();

        // Reset with requester 0 already valid; ready must stay low in reset.
        new_req(0, 3'd3, 16'h1234);
        drive();
        #2;
        apply_reset();
        release_reset();
        tick();
        drain_scrub();
`ifdef RAM_SCRUB_EN
        for (int k = 0; k < RAM_DEPTH; k++) chk("scrub_zero", 32'(mem_rd(k)), 32'd0);
`endif
        drain_pending();

        // Single requester.
        new_req(2, 3'd5, 16'hBEEF);
        tick();
        tick();
        chk("single_mem5", 32'(mem_rd(5)), 32'h0000BEEF);

        // All four continuously valid from reset.
        for (int i = 0; i < NUM_REQ; i++) new_req(i, ADDR_SIZE'($urandom), RAM_WIDTH'($urandom));
        apply_reset();
        release_reset();
        drain_scrub();
        for (int n = 0; n < 3 * NUM_REQ; n++) begin
            tick();
            chk("rr_order", 32'(grant_id), 32'(n % NUM_REQ));
            chk("rr_no_idle", 32'(ram_wr_en), 32'd1);
            for (int i = 0; i < NUM_REQ; i++)
                if (!pend[i]) new_req(i, ADDR_SIZE'($urandom), RAM_WIDTH'($urandom));
        end
        drain_pending();

        // Pointer at 1, then 1 and 3 both write address 0.
        new_req(1, ADDR_SIZE'($urandom), RAM_WIDTH'($urandom));
        tick();
        d1 = RAM_WIDTH'($urandom);
        new_req(1, 3'd0, d1);
        new_req(3, 3'd0, ~d1);
        tick();
        chk("prio_3_first", 32'(grant_id), 32'd3);
        tick();
        chk("prio_then_1", 32'(grant_id), 32'd1);
        tick();
        chk("same_addr_later_wins", 32'(mem_rd(0)), 32'(d1));

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    new_req(i, ADDR_SIZE'($urandom_range(0, RAM_DEPTH - 1)), RAM_WIDTH'($urandom));
            tick();
        end
        drain_pending();

        // Reset while a write is in flight: the write must be dropped.
        old6 = mem_rd(6);
        new_req(2, 3'd6, old6 ^ 16'h5A5A);
        tick();
        chk("inflight_en", 32'(ram_wr_en), 32'd1);
        new_req(1, 3'd1, RAM_WIDTH'($urandom));
        apply_reset();
        chk("dropped_write", 32'(mem_rd(6)), 32'(old6));
        release_reset();
        drain_scrub();
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    new_req(i, ADDR_SIZE'($urandom_range(0, RAM_DEPTH - 1)), RAM_WIDTH'($urandom));
            tick();
        end
        drain_pending();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
